// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: widths, memory op codes,
// FSM state encoding and the request payload.
package dm_arbiter_pkg;

    localparam int unsigned RF_XLEN       = 32;
    localparam int unsigned DM_OPSLEN     = 3;
    localparam int unsigned DM_AW_DEFAULT = 10;

    // Memory access op codes (loads, then stores)
    localparam logic [DM_OPSLEN-1:0] DM_OPS_LB  = 3'(0);
    localparam logic [DM_OPSLEN-1:0] DM_OPS_LH  = 3'(1);
    localparam logic [DM_OPSLEN-1:0] DM_OPS_LW  = 3'(2);
    localparam logic [DM_OPSLEN-1:0] DM_OPS_LBU = 3'(3);
    localparam logic [DM_OPSLEN-1:0] DM_OPS_LHU = 3'(4);
    localparam logic [DM_OPSLEN-1:0] DM_OPS_SB  = 3'(5);
    localparam logic [DM_OPSLEN-1:0] DM_OPS_SH  = 3'(6);
    localparam logic [DM_OPSLEN-1:0] DM_OPS_SW  = 3'(7);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // One requester's access as presented on its port
    typedef struct packed {
        logic                 we;
        logic [DM_OPSLEN-1:0] op;
        logic [RF_XLEN-1:0]   addr;
        logic [RF_XLEN-1:0]   wdata;
    } dm_req_t;

    // True when any address bit at or above the memory width is set
    function automatic logic addr_out_of_range(input logic [RF_XLEN-1:0] addr,
                                               input int unsigned aw);
        return (addr >> aw) != '0;
    endfunction

endpackage

// File: rtl/dm_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins; on contention the
// port that was not granted last time wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt_c
);

    // One-hot (or zero) grant from current requests and last winner
    always_comb begin
        gnt_c    = 2'b00;
        gnt_c[0] = req[0] & (~req[1] | last_gnt);
        gnt_c[1] = req[1] & (~req[0] | ~last_gnt);
    end

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single data-memory port between the core load/store path (port 0)
// and the debug/DMA loader (port 1). One request is accepted at a time; the
// memory is driven for exactly one cycle and the response returns one cycle
// later to the owning port.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int unsigned DM_AW   = DM_AW_DEFAULT,
    parameter logic        RR_INIT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [1:0]           req_i,
    input  logic [1:0]           we_i,
    input  logic [DM_OPSLEN-1:0] op0_i,
    input  logic [DM_OPSLEN-1:0] op1_i,
    input  logic [RF_XLEN-1:0]   addr0_i,
    input  logic [RF_XLEN-1:0]   addr1_i,
    input  logic [RF_XLEN-1:0]   wdata0_i,
    input  logic [RF_XLEN-1:0]   wdata1_i,

    output logic [1:0]           gnt_o,
    output logic [1:0]           rvalid_o,
    output logic [RF_XLEN-1:0]   rdata_o,
    output logic                 err_o,
    output logic                 busy_o,

    output logic                 dm_rd_en,
    output logic                 dm_wr_en,
    output logic [DM_OPSLEN-1:0] dm_rd_op,
    output logic [DM_OPSLEN-1:0] dm_wr_op,
    output logic [RF_XLEN-1:0]   dm_addr,
    output logic [RF_XLEN-1:0]   dm_wdata,
    input  logic [RF_XLEN-1:0]   dm_rdata,
    input  logic                 dm_valid,
    input  logic                 dm_br
);

    state_e             state_q;
    state_e             state_d;
    logic               last_gnt_q;
    logic               owner_q;
    logic               lat_we_q;
    logic               range_err_q;

    logic [1:0]         arb_gnt;
    logic               win;
    dm_req_t            win_req;
    logic               win_oob;
    logic               accept;
    logic               capture;
    logic               err_c;
    logic [RF_XLEN-1:0] resp_data_c;

    rr_arb2 u_rr_arb2 (
        .req      (req_i),
        .last_gnt (last_gnt_q),
        .gnt_c    (arb_gnt)
    );

    assign win = arb_gnt[1];

    // Select the winning port's request fields
    always_comb begin
        if (win) begin
            win_req = '{we: we_i[1], op: op1_i, addr: addr1_i, wdata: wdata1_i};
        end else begin
            win_req = '{we: we_i[0], op: op0_i, addr: addr0_i, wdata: wdata0_i};
        end
        win_oob = addr_out_of_range(win_req.addr, DM_AW);
    end

    // Response status: range errors, store bounds violations, loads the memory did not validate
    assign err_c       = range_err_q
                       | (lat_we_q & dm_br)
                       | (~lat_we_q & ~range_err_q & ~dm_valid);
    assign resp_data_c = (~lat_we_q & ~err_c) ? dm_rdata : '0;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, grant and datapath strobes
    always_comb begin
        state_d = state_q;
        gnt_o   = 2'b00;
        accept  = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_RESP: begin
                if (|req_i) begin
                    gnt_o   = arb_gnt;
                    accept  = 1'b1;
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                capture = 1'b1;
                state_d = ST_RESP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Latch the granted request; memory strobes live only for the ACCESS cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q  <= RR_INIT;
            owner_q     <= 1'b0;
            lat_we_q    <= 1'b0;
            range_err_q <= 1'b0;
            dm_rd_en    <= 1'b0;
            dm_wr_en    <= 1'b0;
            dm_rd_op    <= '0;
            dm_wr_op    <= '0;
            dm_addr     <= '0;
            dm_wdata    <= '0;
        end else if (accept) begin
            last_gnt_q  <= win;
            owner_q     <= win;
            lat_we_q    <= win_req.we;
            range_err_q <= win_oob;
            dm_rd_en    <= ~win_req.we & ~win_oob;
            dm_wr_en    <= win_req.we & ~win_oob;
            dm_rd_op    <= win_req.we ? '0 : win_req.op;
            dm_wr_op    <= win_req.we ? win_req.op : '0;
            dm_addr     <= win_req.addr;
            dm_wdata    <= win_req.wdata;
        end else begin
            dm_rd_en    <= 1'b0;
            dm_wr_en    <= 1'b0;
            dm_rd_op    <= '0;
            dm_wr_op    <= '0;
            dm_addr     <= '0;
            dm_wdata    <= '0;
        end
    end

    // Capture the memory result and present it to the owner for one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_o <= 2'b00;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else if (capture) begin
            rvalid_o <= {owner_q, ~owner_q};
            rdata_o  <= resp_data_c;
            err_o    <= err_c;
        end else begin
            rvalid_o <= 2'b00;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end
    end

    // Busy whenever the FSM is (or is about to be) outside IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_o <= 1'b0;
        end else begin
            busy_o <= (state_d != ST_IDLE);
        end
    end

endmodule
